// File: rtl/counter_seq_pkg.sv
// Shared opcodes, FSM states and reset constants for the counter sequencer.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STEP  = 3'd2,
        OP_LIMIT = 3'd3,
        OP_DIR   = 3'd4,
        OP_RUN   = 3'd5,
        OP_STOP  = 3'd6,
        OP_RSVD  = 3'd7
    } opcode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic        DIR_UP      = 1'b0;
    localparam logic        DIR_DOWN    = 1'b1;
    localparam logic        DIR_RESET   = DIR_UP;
    // Wide constants, sliced down to the configured counter width.
    localparam logic [31:0] STEP_RESET  = 32'd1;
    localparam logic [31:0] LIMIT_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/counter_datapath.sv
// Count register with load port, add/subtract unit with carry/borrow out,
// and equality compare of the updated value against the limit.
module counter_datapath
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             update,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             match
);

    // Extra top bit captures carry (up) or borrow (down) out of WIDTH bits.
    logic [WIDTH:0] result;

    always_comb begin
        if (dir == DIR_DOWN) begin
            result = {1'b0, count} - {1'b0, step};
        end else begin
            result = {1'b0, count} + {1'b0, step};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            match <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            match <= 1'b0;
            if (load) begin
                count <= load_value;
            end else if (update) begin
                count <= result[WIDTH-1:0];
                wrap  <= result[WIDTH];
                match <= (result[WIDTH-1:0] == limit);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer: configuration registers, burst FSM and the
// remaining-update counter around the counter datapath.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             match
);

    opcode_t          op;
    state_t           state;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] remaining;
    logic             dir;
    logic             free_run;
    logic             accept;
    logic             load;
    logic             update;

    assign op        = opcode_t'(cmd_op);
    assign cmd_ready = ena & ((state == ST_IDLE) | (op == OP_STOP));
    assign accept    = cmd_valid & cmd_ready;
    assign load      = accept & (state == ST_IDLE) & (op == OP_LOAD);
    // An accepted STOP in RUN suppresses the update on its edge.
    assign update    = ena & (state == ST_RUN) & ~accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step      <= STEP_RESET[WIDTH-1:0];
            limit     <= LIMIT_RESET[WIDTH-1:0];
            dir       <= DIR_RESET;
            remaining <= '0;
            free_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ena) begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            case (op)
                                OP_STEP:  step  <= cmd_data;
                                OP_LIMIT: limit <= cmd_data;
                                OP_DIR:   dir   <= cmd_data[0];
                                OP_RUN: begin
                                    state     <= ST_RUN;
                                    busy      <= 1'b1;
                                    remaining <= cmd_data;
                                    free_run  <= (cmd_data == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (!free_run) begin
                            remaining <= remaining - 1'b1;
                            // The update on this edge is the last one of the burst.
                            if (remaining == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    counter_datapath #(
        .WIDTH(WIDTH)
    ) datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (cmd_data),
        .update     (update),
        .step       (step),
        .dir        (dir),
        .limit      (limit),
        .count      (count),
        .wrap       (wrap),
        .match      (match)
    );

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for the 8-bit counter datapath behind the TinyTapeout top-level. It accepts opcodes over a valid/ready command port and configures the counter's load value, step, direction and compare limit. It sequences bounded or free-running count bursts and reports completion, wrap and compare events. The top-level maps `cmd_*` from `ui_in`/`uio_in` and drives `uo_out` from `count`.

## Interface

- `WIDTH`, default 8: counter, step, limit and burst-length width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: global enable; low freezes all state and deasserts `cmd_ready`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid & cmd_ready`.
- `cmd_op` in 3: opcode.
- `cmd_data` in WIDTH: opcode operand.
- `count` out WIDTH: current counter value (registered).
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a bounded burst completes.
- `wrap` out 1: one-cycle pulse when an update carries or borrows out of WIDTH bits.
- `match` out 1: one-cycle pulse when the updated `count` equals `limit`.

## Operation

- Opcodes: 0 NOP, 1 LOAD (`count`←data), 2 STEP (`step`←data), 3 LIMIT (`limit`←data), 4 DIR (`dir`←data[0]; 0 up, 1 down), 5 RUN (burst of data updates; 0 = free-run), 6 STOP, 7 reserved (treated as NOP).
- States: IDLE, RUN.
  - IDLE→RUN on accepted RUN.
  - RUN→IDLE when the remaining count reaches zero (bounded), or on an accepted STOP.
- `cmd_ready = ena & (state==IDLE | cmd_op==STOP)`. In RUN only STOP is accepted. STOP in IDLE is a NOP.
- RUN update, once per enabled cycle: `count`←`count` ± `step`, modulo 2^WIDTH. `wrap` is set from the carry/borrow. `match` is set if the new count equals `limit`. For a bounded burst, `remaining` decrements.
- Bounded burst: on the final update, `done`←1 and state←IDLE in the same edge.
- Free-run burst: never asserts `done`.
- STOP takes priority over the update on the same edge. No update occurs on that edge, `done` stays 0, and state goes to IDLE.
- `step`=0 is legal. Count holds, `remaining` still decrements, and `match` still evaluates.
- `ena` low: `count`, `remaining`, state and configuration all hold. `done`/`wrap`/`match` are 0.
- Reset values: `count`=0, `step`=1, `limit`=all-ones, `dir`=up, `remaining`=0, state IDLE, `busy`=0, `done`=`wrap`=`match`=0.
- Reset mid-burst aborts the burst with no `done`.

## Timing

- Configuration commands accepted at edge t take effect at t; the new value is visible in cycle t+1.
- RUN with N>0 accepted at edge t0:
  - updates at edges t1..tN;
  - `busy` high in cycles t0+1..tN;
  - `done` high only in the cycle after tN, with `busy` low and `cmd_ready` high in that same cycle.
- `wrap` and `match` are registered alongside the `count` update they describe.
- A command may be accepted in the cycle `done` is high, giving back-to-back bursts with zero idle cycles.

## Structure

- Package `counter_seq_pkg` holds:
  - the opcode enum;
  - the state enum (IDLE, RUN);
  - reset constants for `step`, `limit` and `dir`.
- Sub-module `counter_datapath` holds:
  - the `count` register and its load port;
  - the add/subtract unit with carry/borrow out;
  - the equality compare against `limit`.
- The FSM, configuration registers and `remaining` stay in `counter_sequencer`.

## Test plan

- Reset, then LOAD 0xFE, STEP 1, RUN 3 → `count` 0xFF, 0x00, 0x01. `wrap` pulses with 0x00. `done` pulses with 0x01, 4 cycles after RUN acceptance.
- DIR 1, LOAD 0x05, STEP 2, LIMIT 0x01, RUN 2 → `count` 0x03, 0x01. `match` pulses with 0x01. `done` pulses concurrently. No `wrap`.
- RUN 0 from count 0, then STOP 10 cycles later → `count` reaches 10. No update on the STOP edge. `done` never asserts.
- During RUN 5, drive LOAD with `cmd_valid` → `cmd_ready` stays 0. Once the burst ends, LOAD is accepted in the `done` cycle.
- Mid-burst: `ena` low for 3 cycles, then high → `count` and `remaining` freeze and resume. Total updates remain 5.
- Assert `rst_n` low during RUN 100 → next cycle: `count`=0, `busy`=0, `step`=1, `limit`=0xFF, no `done`.
